// File: rtl/qif_pkg.sv
// Shared QIF types and helpers: current/voltage widths, synaptic FSM states, 8-bit saturation.
// Used by both the synaptic current feeder and the neuron.
package qif_pkg;

  localparam int I_W       = 8;
  localparam int V_W       = 8;
  localparam int ACC_W_DEF = 12;

  typedef logic signed [I_W-1:0] i_syn_t;
  typedef logic signed [7:0]     weight_t;

  typedef enum logic [1:0] {IDLE, DECAY, SCAN, OUT} syn_state_e;

  function automatic i_syn_t sat8(input int v);
    if (v > 127)  return 8'sh7F;
    if (v < -128) return 8'sh80;
    return i_syn_t'(v);
  endfunction

endpackage

// File: rtl/qif_sat_add.sv
// Signed accumulator plus signed 8-bit weight, clamped to the accumulator range instead of wrapping.
module qif_sat_add #(
  parameter int ACC_WIDTH = 12
) (
  input  logic signed [ACC_WIDTH-1:0] acc,
  input  logic signed [7:0]           w,
  output logic signed [ACC_WIDTH-1:0] sum
);

  logic [ACC_WIDTH:0] wide;

  assign wide = {acc[ACC_WIDTH-1], acc} + {{(ACC_WIDTH-7){w[7]}}, w};

  // Differing top two bits of the widened sum mean the true result left the range.
  always_comb begin
    sum = wide[ACC_WIDTH-1:0];
    if (wide[ACC_WIDTH] != wide[ACC_WIDTH-1])
      sum = wide[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                            : {1'b0, {(ACC_WIDTH-1){1'b1}}};
  end

endmodule

// File: rtl/qif_syn_current.sv
// Synaptic current feeder: per tick, leak the accumulator, add weights of spiking inputs serially, emit sat8(acc>>>OUT_SHIFT).
// Optional feature macro: SYN_SPIKE_COUNT_EN adds the saturating spike_cnt output.
module qif_syn_current
  import qif_pkg::*;
#(
  parameter int N_INPUTS    = 4,
  parameter int ACC_WIDTH   = ACC_W_DEF,
  parameter int DECAY_SHIFT = 3,
  parameter int OUT_SHIFT   = 2,
  localparam int AW         = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick,
  input  logic [N_INPUTS-1:0] spike_in,
  input  logic                w_wr_en,
  input  logic [AW-1:0]       w_wr_addr,
  input  logic signed [7:0]   w_wr_data,
  output i_syn_t              I_syn,
  output logic                I_syn_valid,
  output logic                busy,
`ifdef SYN_SPIKE_COUNT_EN
  output logic [15:0]         spike_cnt,
`endif
  output logic                tick_ovr
);

  syn_state_e                   state;
  logic [N_INPUTS-1:0]          mask;
  logic [AW-1:0]                idx;
  logic signed [ACC_WIDTH-1:0]  acc;
  logic signed [ACC_WIDTH-1:0]  acc_add;
  weight_t                      w [N_INPUTS];
  logic [31:0]                  addr_ext;

  assign addr_ext = 32'(w_wr_addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_INPUTS; i++) w[i] <= '0;
    end else if (w_wr_en && (addr_ext < N_INPUTS)) begin
      w[w_wr_addr] <= w_wr_data;
    end
  end

  qif_sat_add #(.ACC_WIDTH(ACC_WIDTH)) u_sat_add (
    .acc (acc),
    .w   (w[idx]),
    .sum (acc_add)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      acc         <= '0;
      mask        <= '0;
      idx         <= '0;
      I_syn       <= '0;
      I_syn_valid <= 1'b0;
      busy        <= 1'b0;
      tick_ovr    <= 1'b0;
    end else begin
      I_syn_valid <= 1'b0;
      if (tick && (state != IDLE)) tick_ovr <= 1'b1;
      case (state)
        IDLE: begin
          if (tick) begin
            mask  <= spike_in;
            busy  <= 1'b1;
            state <= DECAY;
          end
        end
        DECAY: begin
          // Floor shift: -1 leaks to 0, small positives never leak.
          acc   <= acc - (acc >>> DECAY_SHIFT);
          idx   <= '0;
          state <= SCAN;
        end
        SCAN: begin
          if (mask[idx]) acc <= acc_add;
          if (idx == AW'(N_INPUTS - 1)) state <= OUT;
          else                          idx   <= idx + 1'b1;
        end
        OUT: begin
          I_syn       <= sat8(int'(acc >>> OUT_SHIFT));
          I_syn_valid <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SYN_SPIKE_COUNT_EN
  logic [16:0] cnt_sum;

  assign cnt_sum = {1'b0, spike_cnt} + 17'($countones(mask));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              spike_cnt <= '0;
    else if (state == DECAY) spike_cnt <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
  end
`endif

endmodule

// File: tb/tb_qif_syn_current.sv
// Scoreboard bench for qif_syn_current: a reference model pushes expected I_syn and due cycle per accepted tick.
module tb_qif_syn_current;

  localparam int N = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              tick = 1'b0;
  logic [N-1:0]      spike_in = '0;
  logic              w_wr_en = 1'b0;
  logic [1:0]        w_wr_addr = '0;
  logic signed [7:0] w_wr_data = '0;
  logic signed [7:0] I_syn;
  logic              I_syn_valid;
  logic              busy;
  logic              tick_ovr;
`ifdef SYN_SPIKE_COUNT_EN
  logic [15:0]       spike_cnt;
  int                m_cnt = 0;
`endif

  qif_syn_current dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick        (tick),
    .spike_in    (spike_in),
    .w_wr_en     (w_wr_en),
    .w_wr_addr   (w_wr_addr),
    .w_wr_data   (w_wr_data),
    .I_syn       (I_syn),
    .I_syn_valid (I_syn_valid),
    .busy        (busy),
`ifdef SYN_SPIKE_COUNT_EN
    .spike_cnt   (spike_cnt),
`endif
    .tick_ovr    (tick_ovr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int isyn; int due; } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  int m_acc = 0;
  int m_w[N];
  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input int got, input int expv);
    vectors++;
    if (got != expv) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, expv);
    end
  endtask

  function automatic int clamp_acc(input int v);
    if (v > 2047)  return 2047;
    if (v < -2048) return -2048;
    return v;
  endfunction

  function automatic int clamp8(input int v);
    if (v > 127)  return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  always @(negedge clk) begin
    if (I_syn_valid) begin
      chk("sb_nonempty_at_valid", int'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        chk("i_syn", int'(I_syn), mon_e.isyn);
        chk("latency", cyc, mon_e.due);
        chk("busy_at_valid", int'(busy), 0);
      end
    end
  end

  task automatic wr(input int a, input int d);
    @(negedge clk);
    w_wr_en   = 1'b1;
    w_wr_addr = 2'(a);
    w_wr_data = 8'(d);
    @(negedge clk);
    w_wr_en   = 1'b0;
    m_w[a]    = d;
  endtask

  task automatic do_tick(input logic [N-1:0] s);
    exp_t e;
    @(negedge clk);
    tick     = 1'b1;
    spike_in = s;
    @(posedge clk);
    #1;
    tick     = 1'b0;
    spike_in = ~s;
    m_acc = m_acc - (m_acc >>> 3);
    for (int i = 0; i < N; i++)
      if (s[i]) m_acc = clamp_acc(m_acc + m_w[i]);
`ifdef SYN_SPIKE_COUNT_EN
    m_cnt = m_cnt + $countones(s);
`endif
    e.isyn = clamp8(m_acc >>> 2);
    e.due  = cyc + 6;
    sb.push_back(e);
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && sb.size() > 0; k++) @(negedge clk);
    chk("drain", sb.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < N; i++) m_w[i] = 0;

    // reset state, then idle with no tick
    repeat (3) @(negedge clk);
    chk("rst_i_syn", int'(I_syn), 0);
    chk("rst_valid", int'(I_syn_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ovr", int'(tick_ovr), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_i_syn", int'(I_syn), 0);
    chk("idle_busy", int'(busy), 0);

    // single weight, then pure leak
    wr(0, 40);
    do_tick(4'b0001);
    @(negedge clk);
    chk("busy_running", int'(busy), 1);
    drain();
    chk("single_w_i_syn", int'(I_syn), 10);
    do_tick(4'b0000);
    drain();
    chk("leak1_i_syn", int'(I_syn), 8);
    do_tick(4'b0000);
    drain();
    chk("leak2_i_syn", int'(I_syn), 7);

    // positive saturation with back-to-back ticks every N+3 cycles
    for (int i = 0; i < N; i++) wr(i, 127);
    for (int t = 0; t < 6; t++) begin
      do_tick(4'b1111);
      repeat (6) @(negedge clk);
    end
    drain();
    chk("b2b_no_ovr", int'(tick_ovr), 0);
    chk("sat_pos_i_syn", int'(I_syn), 127);

    for (int i = 0; i < N; i++) wr(i, -128);
    for (int t = 0; t < 8; t++) begin
      do_tick(4'b1111);
      repeat (6) @(negedge clk);
    end
    drain();
    chk("sat_neg_i_syn", int'(I_syn), -128);

    // weight rewritten on the same edge its index is scanned: old value used this tick
    wr(3, 100);
    do_tick(4'b1000);
    repeat (4) @(negedge clk);
    wr(3, -8);
    drain();
    do_tick(4'b1000);
    drain();
    do_tick(4'b0110);
    drain();

    // overrun: second tick two cycles later is ignored
    do_tick(4'b0101);
    @(negedge clk);
    @(negedge clk);
    tick     = 1'b1;
    spike_in = 4'b1111;
    @(negedge clk);
    tick     = 1'b0;
    drain();
    chk("ovr_set", int'(tick_ovr), 1);

    // reset in the middle of SCAN aborts the tick
    do_tick(4'b1111);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb.delete();
    m_acc = 0;
    for (int i = 0; i < N; i++) m_w[i] = 0;
`ifdef SYN_SPIKE_COUNT_EN
    m_cnt = 0;
`endif
    #2;
    chk("abort_i_syn", int'(I_syn), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_ovr", int'(tick_ovr), 0);
    @(negedge clk);
    rst_n = 1'b1;
    wr(1, -20);
    do_tick(4'b0010);
    drain();
    chk("post_reset_i_syn", int'(I_syn), -5);
    repeat (12) @(negedge clk);
    chk("no_stray_valid", sb.size(), 0);

`ifdef SYN_SPIKE_COUNT_EN
    chk("spike_cnt", int'(spike_cnt), m_cnt);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
